// File: rtl/anim_if.sv
// Sprite animation bus: player-FSM request/tick in, sheet offsets out.
interface anim_if;
    logic        anim_tick;
    logic [2:0]  req_state;
    logic [2:0]  cur_state;
    logic [3:0]  frame_idx;
    logic [10:0] anim_row;
    logic [10:0] anim_col;
    logic [5:0]  max_width;
    logic        busy;
    logic        anim_done;
    logic        hitbox_active;

    modport master (
        output anim_tick, req_state,
        input  cur_state, frame_idx, anim_row, anim_col,
        input  max_width, busy, anim_done, hitbox_active
    );

    modport slave (
        input  anim_tick, req_state,
        output cur_state, frame_idx, anim_row, anim_col,
        output max_width, busy, anim_done, hitbox_active
    );
endinterface

// File: rtl/anim_sequencer.sv
// Scheduled frame counter for sprite animations; one counter for all states.
// Optional ANIM_HITBOX_EN build drives hitbox_active during attack frames 2-3.
module anim_sequencer #(
    parameter int FRAME_W   = 46,
    parameter int ROW_PITCH = 46
) (
    input  logic clk,
    input  logic reset,
    anim_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WALK   = 3'd1;
    localparam logic [2:0] JUMP   = 3'd2;
    localparam logic [2:0] FALL   = 3'd3;
    localparam logic [2:0] ATTACK = 3'd4;

    localparam logic [1:0] M_LOOP = 2'd0;
    localparam logic [1:0] M_PARK = 2'd1;
    localparam logic [1:0] M_LOCK = 2'd2;

    logic [2:0] state_q, state_d, req_dec;
    logic [3:0] frame_q, frame_d;
    logic [3:0] hold_q, hold_d;
    logic       parked_q, parked_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] n_frames, n_hold;
    logic [1:0] mode;

    assign req_dec = (bus.req_state > ATTACK) ? IDLE : bus.req_state;

    always_comb begin
        n_frames = 4'd4;
        n_hold   = 4'd8;
        mode     = M_LOOP;
        case (state_q)
            WALK:    begin n_frames = 4'd8; n_hold = 4'd4; mode = M_LOOP; end
            JUMP:    begin n_frames = 4'd3; n_hold = 4'd6; mode = M_PARK; end
            FALL:    begin n_frames = 4'd2; n_hold = 4'd6; mode = M_LOOP; end
            ATTACK:  begin n_frames = 4'd5; n_hold = 4'd3; mode = M_LOCK; end
            default: begin n_frames = 4'd4; n_hold = 4'd8; mode = M_LOOP; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            frame_q  <= 4'd0;
            hold_q   <= 4'd0;
            parked_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            hold_q   <= hold_d;
            parked_q <= parked_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // A state change always wins over a coincident tick.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        hold_d   = hold_q;
        parked_d = parked_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (!busy_q && req_dec != state_q) begin
            state_d  = req_dec;
            frame_d  = 4'd0;
            hold_d   = 4'd0;
            parked_d = 1'b0;
            busy_d   = (req_dec == ATTACK);
        end else if (bus.anim_tick && !parked_q) begin
            if (hold_q < n_hold - 4'd1) begin
                hold_d = hold_q + 4'd1;
            end else begin
                hold_d = 4'd0;
                if (frame_q < n_frames - 4'd1) begin
                    frame_d = frame_q + 4'd1;
                end else begin
                    done_d = 1'b1;
                    case (mode)
                        M_LOOP: frame_d = 4'd0;
                        M_PARK: parked_d = 1'b1;
                        default: begin
                            state_d = req_dec;
                            frame_d = 4'd0;
                            busy_d  = (req_dec == ATTACK);
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        bus.cur_state = state_q;
        bus.frame_idx = frame_q;
        bus.anim_row  = 11'(state_q) * 11'(ROW_PITCH);
        bus.anim_col  = 11'(frame_q) * 11'(FRAME_W);
        bus.max_width = 6'(FRAME_W);
        bus.busy      = busy_q;
        bus.anim_done = done_q;
`ifdef ANIM_HITBOX_EN
        bus.hitbox_active = busy_q && state_q == ATTACK &&
                            (frame_q == 4'd2 || frame_q == 4'd3);
`else
        bus.hitbox_active = 1'b0;
`endif
    end
endmodule

// File: tb/tb_anim_sequencer.sv
// Directed and random checks of anim_sequencer against an elapsed-tick model.
module tb_anim_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    anim_if bus();
    anim_sequencer #(.FRAME_W(46), .ROW_PITCH(46)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int FR[5] = '{4, 8, 3, 2, 5};
    int HO[5] = '{8, 4, 6, 6, 3};
    int MD[5] = '{0, 0, 1, 0, 2}; // 0 loop, 1 park, 2 lock

    int m_state, m_el;
    bit m_busy, m_done;
    int n_checks = 0;
    int n_err = 0;
    int done_cnt, done_at, hit_cnt, first_at;
    bit busy_low;

    function automatic int m_frame();
        int f;
        f = m_el / HO[m_state];
        if (f > FR[m_state] - 1) f = FR[m_state] - 1;
        return f;
    endfunction

    function automatic bit m_hit();
`ifdef ANIM_HITBOX_EN
        return m_busy && m_state == 4 && (m_frame() == 2 || m_frame() == 3);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_el = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_update(input bit t, input int r);
        int d, tot;
        d = (r > 4) ? 0 : r;
        tot = FR[m_state] * HO[m_state];
        m_done = 0;
        if (!m_busy && d != m_state) begin
            m_state = d; m_el = 0; m_busy = (d == 4);
        end else if (t && !(MD[m_state] == 1 && m_el == tot)) begin
            m_el++;
            if (m_el == tot) begin
                m_done = 1;
                if (MD[m_state] == 0) m_el = 0;
                else if (MD[m_state] == 2) begin
                    m_state = d; m_el = 0; m_busy = (d == 4);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cur_state", 16'(bus.cur_state), 16'(m_state));
        chk("frame_idx", 16'(bus.frame_idx), 16'(m_frame()));
        chk("anim_row", 16'(bus.anim_row), 16'(m_state * 46));
        chk("anim_col", 16'(bus.anim_col), 16'(m_frame() * 46));
        chk("max_width", 16'(bus.max_width), 16'd46);
        chk("busy", 16'(bus.busy), 16'(m_busy));
        chk("anim_done", 16'(bus.anim_done), 16'(m_done));
        chk("hitbox", 16'(bus.hitbox_active), 16'(m_hit()));
    endtask

    task automatic step(input bit t, input int r);
        bus.anim_tick = t;
        bus.req_state = 3'(r);
        @(posedge clk);
        model_update(t, r);
        #1;
        check_all();
        if (bus.anim_done === 1'b1) done_cnt++;
        if (bus.hitbox_active === 1'b1) hit_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        bus.anim_tick = 1'b0;
        bus.req_state = 3'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // IDLE loop
        done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 32; i++) begin
            step(1, 0);
            if (bus.anim_done === 1'b1) done_at = i;
            step(0, 0);
        end
        chk("idle_done_cnt", 16'(done_cnt), 16'd1);
        chk("idle_done_at", 16'(done_at), 16'd32);

        // JUMP parks on last frame
        step(0, 2);
        done_cnt = 0; done_at = 0; first_at = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1, 2);
            if (bus.anim_done === 1'b1) done_at = i;
            if (first_at == 0 && bus.frame_idx === 4'd2) first_at = i;
        end
        chk("jump_f2_at", 16'(first_at), 16'd12);
        chk("jump_done_at", 16'(done_at), 16'd18);
        chk("jump_done_cnt", 16'(done_cnt), 16'd1);
        chk("jump_col", 16'(bus.anim_col), 16'd92);
        chk("jump_row", 16'(bus.anim_row), 16'd92);

        // WALK frame 5, then FALL with simultaneous tick
        step(0, 1);
        for (int i = 0; i < 20; i++) step(1, 1);
        chk("walk_f5", 16'(bus.frame_idx), 16'd5);
        step(1, 3);
        chk("fall_state", 16'(bus.cur_state), 16'd3);
        chk("fall_frame", 16'(bus.frame_idx), 16'd0);
        chk("fall_row", 16'(bus.anim_row), 16'd138);

        // ATTACK locks out WALK
        step(0, 4);
        hit_cnt = 0; busy_low = 0; done_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            step(1, 1);
            if (bus.busy !== 1'b1) busy_low = 1;
        end
        chk("atk_busy_held", 16'(busy_low), 16'd0);
        step(1, 1);
        chk("atk_done", 16'(bus.anim_done), 16'd1);
        chk("atk_busy_end", 16'(bus.busy), 16'd0);
        chk("atk_to_walk", 16'(bus.cur_state), 16'd1);
        chk("atk_walk_f0", 16'(bus.frame_idx), 16'd0);
`ifdef ANIM_HITBOX_EN
        chk("atk_hit_cnt", 16'(hit_cnt), 16'd6);
`else
        chk("atk_hit_cnt", 16'(hit_cnt), 16'd0);
`endif

        // ATTACK held back-to-back, then reset mid-attack
        step(0, 4);
        busy_low = 0; done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            step(1, 4);
            if (bus.busy !== 1'b1) busy_low = 1;
        end
        chk("atk_chain_busy", 16'(busy_low), 16'd0);
        chk("atk_chain_done", 16'(done_cnt), 16'd3);
        for (int i = 0; i < 9; i++) step(1, 4);
        chk("atk_f3", 16'(bus.frame_idx), 16'd3);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_state", 16'(bus.cur_state), 16'd0);
        chk("rst_hit", 16'(bus.hitbox_active), 16'd0);
        #2 reset = 1'b1;

        // Code 6 decodes as IDLE
        step(0, 1);
        step(0, 6);
        chk("req6_state", 16'(bus.cur_state), 16'd0);
        chk("req6_row", 16'(bus.anim_row), 16'd0);
        for (int i = 0; i < 10; i++) step(1, 6);

        // Random traffic
        begin
            int r;
            r = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) r = $urandom_range(7);
                step(1'($urandom_range(1)), r);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
